// File: rtl/fpu_cmd_sequencer.sv
// fpu_cmd_sequencer: buffers FPU commands in a small FIFO, issues them one at a
// time to the FPU, waits for completion (or times out) and hands back a tagged
// response with status. Illegal commands (op field not one-hot) are answered
// without ever reaching the FPU.
module fpu_cmd_sequencer #(
   parameter int DEPTH   = 4,     // command queue entries, power of 2 (2..16)
   parameter int TIMEOUT = 255    // WAIT cycles allowed before abort (1..65535)
) (
   input  logic        clk,
   input  logic        rst_l,
   // command push
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [12:0] cmd_op,
   input  logic [31:0] cmd_opa,
   input  logic [31:0] cmd_opb,
   input  logic [31:0] cmd_opc,
   input  logic [2:0]  cmd_frm,
   input  logic [3:0]  cmd_tag,
   // FPU issue
   output logic [31:0] fpu_opA,
   output logic [31:0] fpu_opB,
   output logic [31:0] fpu_opC,
   output logic [2:0]  fpu_frm,
   output logic [12:0] fpu_op_valids,
   // FPU completion
   input  logic [31:0] fpu_result,
   input  logic [12:0] fpu_valids,
   input  logic [4:0]  fpu_exceptions,
   // response
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [4:0]  rsp_flags,
   output logic [3:0]  rsp_tag,
   output logic [1:0]  rsp_status,
   // status / interrupt
   output logic        busy,
   output logic        irq,
   input  logic        irq_clr
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   // Counter value at which the WAIT state gives up.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ILLEGAL = 2'b10;

   typedef struct packed {
      logic [12:0] op;
      logic [31:0] opa;
      logic [31:0] opb;
      logic [31:0] opc;
      logic [2:0]  frm;
      logic [3:0]  tag;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Command queue
   // ------------------------------------------------------------------
   cmd_t            r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   cmd_t            w_in;
   cmd_t            w_head;
   logic [10:0]     w_sel;
   logic            w_onehot;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign cmd_ready = !w_full;
   assign w_push    = cmd_valid && !w_full;

   assign w_in.op   = cmd_op;
   assign w_in.opa  = cmd_opa;
   assign w_in.opb  = cmd_opb;
   assign w_in.opc  = cmd_opc;
   assign w_in.frm  = cmd_frm;
   assign w_in.tag  = cmd_tag;

   assign w_head    = r_mem[r_rd_ptr];

   // A legal command selects exactly one operation in op[12:2].
   assign w_sel     = w_head.op[12:2];
   assign w_onehot  = (w_sel != 11'd0) && ((w_sel & (w_sel - 11'd1)) == 11'd0);

   // Queue storage: written on every accepted push; contents need no reset
   // because emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_in;
      end
   end

   // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------
   state_t        r_state;
   state_t        w_state_next;
   logic [15:0]   r_cnt;
   logic [12:0]   r_op;
   logic [3:0]    r_tag;
   logic [31:0]   r_opa;
   logic [31:0]   r_opb;
   logic [31:0]   r_opc;
   logic [2:0]    r_frm;
   logic [31:0]   r_rsp_result;
   logic [4:0]    r_rsp_flags;
   logic [1:0]    r_rsp_status;
   logic          r_irq;

   logic          w_done;
   logic          w_timeout;
   logic          w_irq_set;
   logic          w_unused;

   // Completion is any operation bit; the mode bits alone do not complete.
   assign w_done    = |fpu_valids[12:2];
   assign w_timeout = (r_cnt == TO_LAST);
   assign w_unused  = ^fpu_valids[1:0];

   // State register.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode plus the FSM-derived outputs.
   always_comb begin
      w_state_next  = r_state;
      w_pop         = 1'b0;
      fpu_op_valids = '0;
      rsp_valid     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_state_next = w_onehot ? S_ISSUE : S_RESP;
            end
         end
         S_ISSUE: begin
            fpu_op_valids = r_op;
            w_state_next  = S_WAIT;
         end
         S_WAIT: begin
            if (w_done || w_timeout) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      busy = (r_state != S_IDLE) || !w_empty;
   end

   // Working registers, timeout counter and response capture.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_op         <= '0;
         r_tag        <= '0;
         r_opa        <= '0;
         r_opb        <= '0;
         r_opc        <= '0;
         r_frm        <= '0;
         r_cnt        <= '0;
         r_rsp_result <= '0;
         r_rsp_flags  <= '0;
         r_rsp_status <= ST_OK;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_op  <= w_head.op;
                  r_tag <= w_head.tag;
                  if (w_onehot) begin
                     // Operands only change when a command really goes to the FPU.
                     r_opa <= w_head.opa;
                     r_opb <= w_head.opb;
                     r_opc <= w_head.opc;
                     r_frm <= w_head.frm;
                  end else begin
                     r_rsp_result <= '0;
                     r_rsp_flags  <= '0;
                     r_rsp_status <= ST_ILLEGAL;
                  end
               end
            end
            S_ISSUE: begin
               r_cnt <= '0;
            end
            S_WAIT: begin
               // Completion wins even in the cycle the counter runs out.
               if (w_done) begin
                  r_rsp_result <= fpu_result;
                  r_rsp_flags  <= fpu_exceptions;
                  r_rsp_status <= ST_OK;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
                  if (w_timeout) begin
                     r_rsp_result <= '0;
                     r_rsp_flags  <= '0;
                     r_rsp_status <= ST_TIMEOUT;
                  end
               end
            end
            default: begin
               // RESP holds everything stable until the handshake.
            end
         endcase
      end
   end

   // Interrupt: set on each entry to RESP; a set in the same cycle as a clear wins.
   assign w_irq_set = (w_state_next == S_RESP) && (r_state != S_RESP);

   // Interrupt flag register.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_irq <= 1'b0;
      end else if (w_irq_set) begin
         r_irq <= 1'b1;
      end else if (irq_clr) begin
         r_irq <= 1'b0;
      end
   end

   assign fpu_opA    = r_opa;
   assign fpu_opB    = r_opb;
   assign fpu_opC    = r_opc;
   assign fpu_frm    = r_frm;
   assign rsp_result = r_rsp_result;
   assign rsp_flags  = r_rsp_flags;
   assign rsp_tag    = r_tag;
   assign rsp_status = r_rsp_status;
   assign irq        = r_irq;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Testbench for fpu_cmd_sequencer: directed steps with a response scoreboard
// and a small FPU responder whose completion latency is set per step.
module tb_fpu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [12:0] cmd_op;
   logic [31:0] cmd_opa;
   logic [31:0] cmd_opb;
   logic [31:0] cmd_opc;
   logic [2:0]  cmd_frm;
   logic [3:0]  cmd_tag;
   logic [31:0] fpu_opA;
   logic [31:0] fpu_opB;
   logic [31:0] fpu_opC;
   logic [2:0]  fpu_frm;
   logic [12:0] fpu_op_valids;
   logic [31:0] fpu_result;
   logic [12:0] fpu_valids;
   logic [4:0]  fpu_exceptions;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [4:0]  rsp_flags;
   logic [3:0]  rsp_tag;
   logic [1:0]  rsp_status;
   logic        busy;
   logic        irq;
   logic        irq_clr;

   always #5 clk = ~clk;

   fpu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(8)) dut (
      .clk            (clk),
      .rst_l          (rst_l),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .cmd_opa        (cmd_opa),
      .cmd_opb        (cmd_opb),
      .cmd_opc        (cmd_opc),
      .cmd_frm        (cmd_frm),
      .cmd_tag        (cmd_tag),
      .fpu_opA        (fpu_opA),
      .fpu_opB        (fpu_opB),
      .fpu_opC        (fpu_opC),
      .fpu_frm        (fpu_frm),
      .fpu_op_valids  (fpu_op_valids),
      .fpu_result     (fpu_result),
      .fpu_valids     (fpu_valids),
      .fpu_exceptions (fpu_exceptions),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_result     (rsp_result),
      .rsp_flags      (rsp_flags),
      .rsp_tag        (rsp_tag),
      .rsp_status     (rsp_status),
      .busy           (busy),
      .irq            (irq),
      .irq_clr        (irq_clr)
   );

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] result;
      logic [4:0]  flags;
      logic [1:0]  status;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          fpu_lat  = 1;     // 0 means the FPU never completes
   int          fpu_cd   = 0;
   logic [12:0] fpu_hold = '0;
   int          pulse_cnt = 0;
   logic [12:0] last_pulse = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // FPU model: completes N cycles after the issue pulse with result opA+opB
   // and exceptions taken from opC[4:0].
   initial begin
      fpu_valids = '0;
      fpu_result = '0;
      fpu_exceptions = '0;
      forever begin
         @(negedge clk);
         fpu_valids = '0;
         fpu_result = '0;
         fpu_exceptions = '0;
         if (fpu_cd > 0) begin
            fpu_cd--;
            if (fpu_cd == 0) begin
               fpu_valids = fpu_hold;
               fpu_result = fpu_opA + fpu_opB;
               fpu_exceptions = fpu_opC[4:0];
            end
         end
         if (fpu_op_valids != '0 && fpu_lat > 0) begin
            fpu_cd = fpu_lat;
            fpu_hold = fpu_op_valids;
         end
      end
   end

   // Issue-pulse monitor, sampled just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (fpu_op_valids != '0) begin
            pulse_cnt++;
            last_pulse = fpu_op_valids;
         end
      end
   end

   // Response collector: compares every handshaken response with the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rsp_valid && rsp_ready) begin
            check("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               $display("rsp tag=%0d status=%0d result=%08h flags=%02h", rsp_tag, rsp_status, rsp_result, rsp_flags);
               check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
               check("rsp_status", 32'(rsp_status), 32'(e.status));
               check("rsp_result", rsp_result, e.result);
               check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
            end
         end
      end
   end

   // Push one command (caller is at a falling edge) and queue its expected response.
   task automatic push(input logic [12:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [2:0] frm, input logic [3:0] tag,
                       input logic [1:0] st);
      exp_t e;
      int n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("push_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_opa = a;
      cmd_opb = b;
      cmd_opc = c;
      cmd_frm = frm;
      cmd_tag = tag;
      e.tag = tag;
      e.status = st;
      e.result = (st == 2'd0) ? a + b : 32'd0;
      e.flags = (st == 2'd0) ? c[4:0] : 5'd0;
      sb.push_back(e);
      $display("push tag=%0d op=%04h exp_status=%0d", tag, op, st);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Wait for rsp_valid; n counts cycles with the push cycle as cycle 0.
   task automatic wait_rsp(output int n);
      n = 1;
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
   endtask

   task automatic ack();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      int n;
      int k;
      int seen;
      logic [12:0] ops [5];
      ops[0] = 13'h0008;
      ops[1] = 13'h0042;
      ops[2] = 13'h0201;
      ops[3] = 13'h0803;
      ops[4] = 13'h0003;

      rst_l = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = '0;
      cmd_opa = '0;
      cmd_opb = '0;
      cmd_opc = '0;
      cmd_frm = '0;
      cmd_tag = '0;
      rsp_ready = 1'b0;
      irq_clr = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_op_valids", 32'(fpu_op_valids), 32'd0);
      check("rst_opA", fpu_opA, 32'd0);
      check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
      rst_l = 1'b1;
      @(negedge clk);

      // Basic op, FPU completes 2 cycles after issue
      fpu_lat = 2;
      pulse_cnt = 0;
      push(13'h0004, 32'h3F800000, 32'h0, 32'h1, 3'd1, 4'd3, 2'd0);
      wait_rsp(n);
      check("t1_pulses", 32'(pulse_cnt), 32'd1);
      check("t1_pulse_val", 32'(last_pulse), 32'h0004);
      check("t1_result", rsp_result, 32'h3F800000);
      check("t1_flags", 32'(rsp_flags), 32'h01);
      check("t1_tag", 32'(rsp_tag), 32'd3);
      check("t1_status", 32'(rsp_status), 32'd0);
      check("t1_irq", 32'(irq), 32'd1);
      check("t1_opA_hold", fpu_opA, 32'h3F800000);
      check("t1_no_pulse_resp", 32'(fpu_op_valids), 32'd0);
      @(negedge clk);
      check("t1_hold_valid", 32'(rsp_valid), 32'd1);
      check("t1_hold_result", rsp_result, 32'h3F800000);
      ack();
      check("t1_idle_busy", 32'(busy), 32'd0);
      check("t1_irq_kept", 32'(irq), 32'd1);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      check("t1_irq_cleared", 32'(irq), 32'd0);

      // Minimum latency with 1-cycle FPU
      fpu_lat = 1;
      push(13'h0401, 32'd10, 32'd20, 32'd5, 3'd2, 4'd7, 2'd0);
      wait_rsp(n);
      check("t2_latency", 32'(n), 32'd4);
      ack();

      // Illegal op, irq set and clear in the same cycle
      irq_clr = 1'b1;
      pulse_cnt = 0;
      push(13'h000C, 32'd1, 32'd2, 32'd3, 3'd0, 4'd5, 2'd2);
      wait_rsp(n);
      check("t3_latency", 32'(n), 32'd2);
      check("t3_no_pulse", 32'(pulse_cnt), 32'd0);
      check("t3_status", 32'(rsp_status), 32'd2);
      check("t3_irq_set_wins", 32'(irq), 32'd1);
      @(negedge clk);
      check("t3_irq_clr", 32'(irq), 32'd0);
      irq_clr = 1'b0;
      ack();

      // Timeout: FPU never completes, 8 WAIT cycles
      fpu_lat = 0;
      push(13'h1000, 32'd4, 32'd4, 32'd4, 3'd3, 4'd9, 2'd1);
      wait_rsp(n);
      check("t4_timeout_latency", 32'(n), 32'd11);
      check("t4_status", 32'(rsp_status), 32'd1);
      ack();
      check("t4_back_idle", 32'(busy), 32'd0);

      // Completion in the very cycle the counter runs out counts as success
      fpu_lat = 8;
      push(13'h0010, 32'd100, 32'd1, 32'd2, 3'd4, 4'd10, 2'd0);
      wait_rsp(n);
      check("t5_latency", 32'(n), 32'd11);
      check("t5_status", 32'(rsp_status), 32'd0);
      ack();

      // One cycle too late: timeout, and the late completion in RESP is ignored
      fpu_lat = 9;
      push(13'h0020, 32'd7, 32'd8, 32'd9, 3'd5, 4'd11, 2'd1);
      wait_rsp(n);
      check("t6_latency", 32'(n), 32'd11);
      @(negedge clk);
      check("t6_late_result", rsp_result, 32'd0);
      check("t6_late_status", 32'(rsp_status), 32'd1);
      ack();

      // Five back-to-back pushes with rsp_ready low; queue fills
      fpu_lat = 1;
      for (int i = 0; i < 5; i++) begin
         push(ops[i], 32'(i * 16), 32'(i), 32'(i + 16), 3'(i), 4'(i + 1),
              (i == 4) ? 2'd2 : 2'd0);
      end
      check("t7_full_ready", 32'(cmd_ready), 32'd0);
      check("t7_busy", 32'(busy), 32'd1);
      rsp_ready = 1'b1;
      k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      rsp_ready = 1'b0;
      check("t7_drained", 32'(sb.size()), 32'd0);
      @(negedge clk);
      check("t7_ready_again", 32'(cmd_ready), 32'd1);
      check("t7_idle", 32'(busy), 32'd0);

      // Reset during WAIT with two commands queued
      rsp_ready = 1'b1;
      fpu_lat = 6;
      push(13'h0004, 32'd1, 32'd1, 32'd1, 3'd0, 4'd12, 2'd0);
      push(13'h0008, 32'd2, 32'd2, 32'd2, 3'd0, 4'd13, 2'd0);
      push(13'h0010, 32'd3, 32'd3, 32'd3, 3'd0, 4'd14, 2'd0);
      check("t8_busy_before", 32'(busy), 32'd1);
      rst_l = 1'b0;
      #1;
      sb.delete();
      check("t8_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t8_cmd_ready", 32'(cmd_ready), 32'd1);
      check("t8_busy", 32'(busy), 32'd0);
      check("t8_irq", 32'(irq), 32'd0);
      check("t8_opA", fpu_opA, 32'd0);
      check("t8_op_valids", 32'(fpu_op_valids), 32'd0);
      @(negedge clk);
      rst_l = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      check("t8_no_rsp_after_reset", 32'(seen), 32'd0);
      check("t8_idle_after", 32'(busy), 32'd0);
      rsp_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
